soc_system_led_pio: RTL
=======================

Name: soc_system_led_pio

Overview:
- Avalon-MM slave output PIO driving the board LEDs.
- Write-side counterpart of the switch input PIO. Same HPS lightweight bridge, same read latency of 1 and 32-bit data bus.
- Adds an atomic bit set/clear path and a per-bit hardware blink engine, so software can flash LEDs without periodic writes.

Parameters:
- DATA_WIDTH, 10, number of LED outputs (1..32).
- RESET_VALUE, 0, reset value of the data register (DATA_WIDTH bits).
- PERIOD_RESET, 25000000, reset value of the blink half-period register, in clk cycles.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  3  Avalon word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe; a write requires chipselect=1 and write_n=0.
- writedata  input  32  write data.
- readdata  output  32  registered read data.
- out_port  output  DATA_WIDTH  registered LED drive.

Behaviour:
- Register map (word address):
  - 0: DATA, RW, DATA_WIDTH bits.
  - 1: BLINK_MASK, RW, DATA_WIDTH bits.
  - 2: PERIOD, RW, 32 bits.
  - 3: STATUS, RO; bit0 = phase, others 0.
  - 4: OUTSET, WO.
  - 5: OUTCLEAR, WO.
  - 6, 7: reserved, read 0, writes ignored.
- Writes take effect at the clock edge where the write is sampled. No waitrequest; every access takes 1 cycle.
  - DATA <= writedata[DATA_WIDTH-1:0].
  - OUTSET: DATA <= DATA | writedata[DATA_WIDTH-1:0].
  - OUTCLEAR: DATA <= DATA & ~writedata[DATA_WIDTH-1:0].
  - Upper writedata bits beyond DATA_WIDTH are ignored.
- Reads:
  - readdata is registered every cycle from the address mux, independent of chipselect and write_n. Read latency is 1.
  - Unused upper bits are zero-extended.
  - OUTSET, OUTCLEAR and reserved addresses read 0.
  - readdata reflects register contents before any write sampled on the same edge.
- Blink engine: 32-bit counter cnt and 1-bit phase.
  - If PERIOD == 0: cnt held at 0, phase held at 1.
  - Else each cycle: if cnt == PERIOD-1 then cnt <= 0 and phase <= ~phase; otherwise cnt <= cnt+1.
  - A write to PERIOD sets cnt <= 0 and phase <= 1 on the same edge. The write takes priority over a coincident wrap.
  - If PERIOD is rewritten to a value <= the current cnt, the write's counter reset still applies, so no 2^32 runaway occurs.
- Output:
  - out_port <= DATA & (~BLINK_MASK | {DATA_WIDTH{phase}}), registered, using register values present before the edge.
  - A write to DATA or OUTSET at edge N therefore appears on out_port at edge N+1.
  - Bits with BLINK_MASK=0 follow DATA. Bits with BLINK_MASK=1 show DATA while phase=1 and 0 while phase=0.
- Reset (synchronous, held for any number of cycles, may occur mid-blink or mid-access):
  - DATA=RESET_VALUE, BLINK_MASK=0, PERIOD=PERIOD_RESET, cnt=0, phase=1.
  - readdata=0.
  - out_port=0 on the reset edge; out_port reflects RESET_VALUE one cycle after reset deasserts.
  - A write coincident with reset is discarded.
- Write with chipselect=0 or write_n=1: no register change.

Test Plan:
- Reset check: assert reset 3 cycles with RESET_VALUE=0 -> readdata=0, out_port=0, read addr 2 returns 25000000, addr 3 returns 1.
- Data path: write 0x2A5 to addr 0, then read addr 0 -> readdata=0x2A5 one cycle after the read cycle; out_port=0x2A5 one cycle after the write edge. Write 0xFFFFFC00 -> DATA=0x000.
- Set/clear: DATA=0x0F0; write 0x003 to addr 4 -> 0x0F3; write 0x030 to addr 5 -> 0x0C3. Read addr 4 -> 0.
- Blink: PERIOD=4, BLINK_MASK=0x001, DATA=0x003 -> out_port alternates 0x003 and 0x002 every 4 cycles. Bit1 stays constant. STATUS bit0 toggles every 4 cycles.
- Blink boundaries:
  - Write PERIOD=0 mid-blink -> phase=1, out_port=0x003 steady.
  - Write PERIOD=2 on the exact cycle cnt==PERIOD-1 -> cnt=0 and phase=1, with no extra toggle.
  - PERIOD=1 -> phase toggles every cycle.
- Reset mid-operation: with blinking active and a write of 0x3FF to addr 0 in the same cycle as reset -> DATA=RESET_VALUE, BLINK_MASK=0, PERIOD=25000000, and the write has no effect.

Source files
------------

// File: rtl/soc_system_led_pio.sv
// Avalon-MM output PIO for the board LEDs with atomic set/clear and a per-bit
// hardware blink engine driven by a programmable half-period counter.
module soc_system_led_pio #(
  parameter int unsigned            DATA_WIDTH   = 10,
  parameter logic [DATA_WIDTH-1:0]  RESET_VALUE  = '0,
  parameter logic [31:0]            PERIOD_RESET = 32'd25000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [2:0] AddrData     = 3'd0;
  localparam logic [2:0] AddrMask     = 3'd1;
  localparam logic [2:0] AddrPeriod   = 3'd2;
  localparam logic [2:0] AddrStatus   = 3'd3;
  localparam logic [2:0] AddrOutSet   = 3'd4;
  localparam logic [2:0] AddrOutClear = 3'd5;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [31:0]           period_q, period_d;
  logic [31:0]           cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic [31:0]           rdata_d;
  logic [DATA_WIDTH-1:0] out_d;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wdata;

  assign wr_en = chipselect & ~write_n;
  assign wdata = writedata[DATA_WIDTH-1:0];

  always_comb begin
    data_d   = data_q;
    mask_d   = mask_q;
    period_d = period_q;
    if (wr_en) begin
      case (address)
        AddrData:     data_d   = wdata;
        AddrMask:     mask_d   = wdata;
        AddrPeriod:   period_d = writedata;
        AddrOutSet:   data_d   = data_q | wdata;
        AddrOutClear: data_d   = data_q & ~wdata;
        default:      ;
      endcase
    end
  end

  // A PERIOD write restarts the half-period and wins over a coincident wrap.
  always_comb begin
    cnt_d   = cnt_q + 32'd1;
    phase_d = phase_q;
    if (wr_en && address == AddrPeriod) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (period_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == period_q - 32'd1) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_comb begin
    rdata_d = '0;
    case (address)
      AddrData:   rdata_d = 32'(data_q);
      AddrMask:   rdata_d = 32'(mask_q);
      AddrPeriod: rdata_d = period_q;
      AddrStatus: rdata_d = {31'd0, phase_q};
      default:    rdata_d = '0;
    endcase
  end

  assign out_d = data_q & (~mask_q | {DATA_WIDTH{phase_q}});

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= RESET_VALUE;
      mask_q   <= '0;
      period_q <= PERIOD_RESET;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
      readdata <= '0;
      out_port <= '0;
    end else begin
      data_q   <= data_d;
      mask_q   <= mask_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      readdata <= rdata_d;
      out_port <= out_d;
    end
  end

endmodule
